// File: rtl/l1d_refill_ctrl_pkg.sv
// Shared types and constants for the L1 D-cache line refill controller.
package l1d_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 512;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  // Refill controller states; one miss is outstanding at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } refill_state_e;

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    line_align = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l1d_refill_ctrl_sat_counter.sv
// Saturating up-counter used for the refill statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count increment requests, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/l1d_refill_ctrl.sv
// L1 D-cache refill controller: accepts one miss, issues a single-cycle line
// request, waits for the line with timeout and bounded retry, and hands the
// line (or an error fill) back to the cache.
//
// Handshakes: a miss transfers on a rising edge where miss_valid && miss_ready;
// a fill transfers on a rising edge where fill_valid && fill_ready, and
// fill_valid/fill_addr/fill_data/fill_err stay stable until that edge.
// mem_req_valid is a one-cycle pulse with no ready (memory always accepts);
// mem_resp_valid is a one-cycle pulse that is only honoured in WAIT.
// Every output comes straight from a register.
import l1d_pkg::*;

module l1d_refill_ctrl #(
  parameter int ADDR_W  = l1d_pkg::ADDR_W,
  parameter int LINE_W  = l1d_pkg::LINE_W,
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_err,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_miss,
  output logic [CNT_W-1:0]  stat_timeout,
  output logic [CNT_W-1:0]  stat_spurious,
  output logic [1:0]        dbg_state
);

  // Timer counts 0..TIMEOUT-1; retry counter counts 0..RETRIES.
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam int RTY_W = $clog2(RETRIES + 1) + 1;

  refill_state_e     r_state;
  logic [ADDR_W-1:0] r_line_addr;
  logic [TMR_W-1:0]  r_timer;
  logic [RTY_W-1:0]  r_retry;

  logic              r_miss_ready;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_req_addr;
  logic              r_fill_valid;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [LINE_W-1:0] r_fill_data;
  logic              r_fill_err;
  logic              r_busy;

  logic [ADDR_W-1:0] w_miss_line;
  logic              w_accept;
  logic              w_timer_done;
  logic              w_timeout;
  logic              w_can_retry;
  logic              w_spurious;

  assign w_miss_line  = line_align(miss_addr);
  assign w_accept     = (r_state == IDLE) && miss_valid;
  assign w_timer_done = (r_timer == TMR_W'(TIMEOUT - 1));
  // A response in the timeout cycle wins, so the timeout needs no response.
  assign w_timeout    = (r_state == WAIT) && !mem_resp_valid && w_timer_done;
  assign w_can_retry  = (r_retry < RTY_W'(RETRIES));
  // Any response outside WAIT is dropped and counted.
  assign w_spurious   = mem_resp_valid && (r_state != WAIT);

  // Refill sequencing; outputs are registered alongside the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_line_addr     <= '0;
      r_timer         <= '0;
      r_retry         <= '0;
      r_miss_ready    <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_fill_valid    <= 1'b0;
      r_fill_addr     <= '0;
      r_fill_data     <= '0;
      r_fill_err      <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state         <= REQ;
            r_line_addr     <= w_miss_line;
            r_retry         <= '0;
            r_miss_ready    <= 1'b0;
            r_busy          <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= w_miss_line;
          end
        end

        REQ: begin
          // The request pulse lasts exactly this one cycle; the address
          // stays up through WAIT so memory may still look at it.
          r_state         <= WAIT;
          r_timer         <= '0;
          r_mem_req_valid <= 1'b0;
        end

        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (mem_resp_valid) begin
            r_state        <= FILL;
            r_fill_data    <= mem_resp_data;
            r_fill_err     <= 1'b0;
            r_fill_valid   <= 1'b1;
            r_fill_addr    <= r_line_addr;
            r_mem_req_addr <= '0;
          end else if (w_timer_done) begin
            if (w_can_retry) begin
              r_state         <= REQ;
              r_retry         <= r_retry + RTY_W'(1);
              r_mem_req_valid <= 1'b1;
            end else begin
              r_state        <= FILL;
              r_fill_data    <= '0;
              r_fill_err     <= 1'b1;
              r_fill_valid   <= 1'b1;
              r_fill_addr    <= r_line_addr;
              r_mem_req_addr <= '0;
            end
          end
        end

        FILL: begin
          // No IDLE bypass: a new miss is accepted the cycle after the fill.
          if (fill_ready) begin
            r_state      <= IDLE;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_miss_ready <= 1'b1;
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stat_miss (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_accept),
    .o_count (stat_miss)
  );

  sat_counter #(.W(CNT_W)) u_stat_timeout (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_timeout),
    .o_count (stat_timeout)
  );

  sat_counter #(.W(CNT_W)) u_stat_spurious (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_spurious),
    .o_count (stat_spurious)
  );

  assign miss_ready    = r_miss_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign fill_valid    = r_fill_valid;
  assign fill_addr     = r_fill_addr;
  assign fill_data     = r_fill_data;
  assign fill_err      = r_fill_err;
  assign busy          = r_busy;
  assign dbg_state     = r_state;

endmodule
